// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants, slot width helper
// and slot index type for the TDM receive path.
package tdm_pkg;

  localparam int NCH_DEFAULT = 4;

  function automatic int selw_f(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int SELW_DEFAULT = selw_f(NCH_DEFAULT);

  typedef logic [SELW_DEFAULT-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrap-around slot index.
// sync loads 0, or 1 when a beat lands at the same time.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int SELW = SELW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            sync,
  output logic [SELW-1:0] count
);

  // slot advances per beat; power-of-two lane count wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (sync) begin
      count <= inc ? SELW'(1) : '0;
    end else if (inc) begin
      count <= count + SELW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: collects one beat per slot into lane
// registers and emits each full frame through a 1-deep buffer.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int NCH   = NCH_DEFAULT,
  localparam int SELW = selw_f(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 sync_in,
  output logic [SELW-1:0]      sel_out,
  output logic [NCH*WIDTH-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  logic [WIDTH-1:0]     lane_q [NCH];
  logic [SELW-1:0]      wr_idx;
  logic                 complete;
  logic                 accept;
  logic                 drop;
  logic [NCH*WIDTH-1:0] assembled;

  tdm_slot_counter #(
    .SELW (SELW)
  ) u_slot (
    .clk   (clk),
    .reset (reset),
    .inc   (in_valid),
    .sync  (sync_in),
    .count (sel_out)
  );

  // a sync beat always lands in lane 0; last lane closes the frame
  always_comb begin
    wr_idx   = sync_in ? '0 : sel_out;
    complete = in_valid && (wr_idx == SELW'(NCH - 1));
    accept   = complete && (!frame_valid || frame_ready);
    drop     = complete && !accept;
  end

  // frame word is the stored lanes with this cycle's beat merged in
  always_comb begin
    assembled = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_valid && (wr_idx == SELW'(i))) begin
        assembled[i*WIDTH +: WIDTH] = in_data;
      end else begin
        assembled[i*WIDTH +: WIDTH] = lane_q[i];
      end
    end
  end

  // lane registers keep stale data across frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        lane_q[i] <= '0;
      end
    end else if (in_valid) begin
      lane_q[wr_idx] <= in_data;
    end
  end

  // one-entry output buffer; refill allowed on the draining cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (accept) begin
      frame_data  <= assembled;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  // sticky drop flag; a new drop beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed scenarios plus random traffic,
// checked against a frame-level model and a scoreboard queue.
module tb_tdm_demux4;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [0:0] in_data;
  logic       sync_in;
  logic [1:0] sel_out;
  logic [3:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       overrun;
  logic       clear_overrun;

  int checks = 0;
  int errors = 0;

  int        m_slot;
  int        m_lane [NCH];
  bit        m_full;
  bit        m_ovr;
  bit  [3:0] exp_q [$];

  always #5 clk = ~clk;

  tdm_demux4 #(
    .WIDTH (1),
    .NCH   (NCH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .sync_in       (sync_in),
    .sel_out       (sel_out),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: slot pointer, lane values, 1-deep output slot
  always @(posedge clk or posedge reset) begin
    int       idx;
    bit       done;
    bit       dropped;
    bit [3:0] word;
    if (reset) begin
      m_slot = 0;
      m_full = 0;
      m_ovr  = 0;
      foreach (m_lane[i]) m_lane[i] = 0;
      exp_q.delete();
    end else begin
      idx     = sync_in ? 0 : m_slot;
      dropped = 0;
      done    = in_valid && (idx == NCH - 1);
      if (in_valid) begin
        m_lane[idx] = int'(in_data);
        m_slot      = (idx + 1) % NCH;
      end else if (sync_in) begin
        m_slot = 0;
      end
      if (done) begin
        for (int i = 0; i < NCH; i++) word[i] = m_lane[i][0];
        if (!m_full || frame_ready) begin
          exp_q.push_back(word);
          m_full = 1;
        end else begin
          m_ovr   = 1;
          dropped = 1;
        end
      end else if (m_full && frame_ready) begin
        m_full = 0;
      end
      if (clear_overrun && !dropped) m_ovr = 0;
    end
  end

  // monitor: state checks every cycle, scoreboard pop on transfer
  always @(negedge clk) begin
    bit [3:0] e;
    if (reset === 1'b1) begin
      chk("rst_sel", sel_out, 0);
      chk("rst_valid", frame_valid, 0);
      chk("rst_data", frame_data, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      chk("sel_out", sel_out, m_slot);
      chk("frame_valid", frame_valid, m_full);
      chk("overrun", overrun, m_ovr);
      if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h expected none at %0t",
                   frame_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_frame", frame_data, e);
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit d, input bit s,
                     input bit r, input bit cl);
    in_valid      = v;
    in_data       = d;
    sync_in       = s;
    reset         = r;
    clear_overrun = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input bit [3:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(1, b[i], 0, 0, 0);
  endtask

  initial begin
    in_valid      = 0;
    in_data       = 0;
    sync_in       = 0;
    reset         = 1;
    clear_overrun = 0;
    frame_ready   = 0;
    @(posedge clk);
    #1;

    // reset held with random inputs
    repeat (3) begin
      frame_ready = 1'($urandom);
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1, 1'($urandom));
    end
    cyc(0, 0, 0, 0, 0);

    // basic frame: lanes 0..3 = 1,0,1,1
    frame_ready = 1;
    beats(4'b1101, 4);
    chk("basic_data", frame_data, 4'b1101);
    chk("basic_valid", frame_valid, 1);
    chk("basic_sel", sel_out, 0);
    cyc(0, 0, 0, 0, 0);
    chk("basic_one_cycle", frame_valid, 0);

    // backpressure: second frame dropped
    frame_ready = 0;
    beats(4'b1101, 4);
    beats(4'b0110, 4);
    chk("bp_data", frame_data, 4'b1101);
    chk("bp_overrun", overrun, 1);
    frame_ready = 1;
    cyc(0, 0, 0, 0, 0);
    chk("bp_drained", frame_valid, 0);
    chk("bp_sticky", overrun, 1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_cleared", overrun, 0);

    // sync without a beat discards the partial frame
    beats(4'b0011, 2);
    cyc(0, 0, 1, 0, 0);
    chk("sync_sel", sel_out, 0);
    chk("sync_noframe", frame_valid, 0);
    beats(4'b0100, 4);
    chk("sync_data", frame_data, 4'b0100);
    cyc(0, 0, 0, 0, 0);

    // sync on a beat puts it in lane 0
    beats(4'b0011, 2);
    cyc(1, 1, 1, 0, 0);
    chk("sync_beat_sel", sel_out, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("sync_beat_data", frame_data, 4'b1101);
    cyc(0, 0, 0, 0, 0);

    // gapped beats 1,1,0,1
    for (int i = 0; i < 4; i++) begin
      bit [3:0] g;
      g = 4'b1011;
      cyc(1, g[i], 0, 0, 0);
      if (i < 3) repeat ($urandom_range(2, 5)) cyc(0, 0, 0, 0, 0);
    end
    chk("gap_data", frame_data, 4'b1011);
    chk("gap_valid", frame_valid, 1);
    cyc(0, 0, 0, 0, 0);
    chk("gap_once", frame_valid, 0);

    // reset mid-frame
    beats(4'b0010, 3);
    cyc(0, 0, 0, 1, 0);
    beats(4'b1111, 3);
    chk("rmid_noframe", frame_valid, 0);
    cyc(1, 1, 0, 0, 0);
    chk("rmid_data", frame_data, 4'b1111);
    chk("rmid_valid", frame_valid, 1);
    cyc(0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      frame_ready = ($urandom % 4) != 0;
      cyc(($urandom % 4) != 0, 1'($urandom),
          ($urandom % 40) == 0, ($urandom % 700) == 0,
          ($urandom % 25) == 0);
    end

    frame_ready = 1;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
